// File: rtl/neuron_pkg.sv
// Shared types and helpers for the LIF neuron array.
// FSM states, reset-mode codes, saturation limits.
package neuron_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam logic RESET_ZERO     = 1'b0;
  localparam logic RESET_SUBTRACT = 1'b1;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/neuron_sat_add.sv
// Signed saturating adder of width W.
// a_i + b_i clamped to the W-bit signed range on sum_o.
module neuron_sat_add
  import neuron_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  localparam logic signed [W-1:0] MAXV = W'(sat_max(W));
  localparam logic signed [W-1:0] MINV = W'(sat_min(W));

  logic [W:0] s;

  assign s = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    sum_o = s[W-1:0];
    if (s[W] != s[W-1]) begin
      sum_o = s[W] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/neuron_array_lif.sv
// Array of leaky integrate-and-fire neurons with scan FSM.
// Ports: update in, tick/scan control, spike out, debug read.
module neuron_array_lif
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS            = 8,
  parameter int BIT_WIDTH_ADDR         = 3,
  parameter int BIT_WIDTH_MEMBRANE     = 16,
  parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
  parameter int BIT_WIDTH_REFRAC       = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     threshold_i,
  input  logic [3:0]                               leak_shift_i,
  input  logic                                     reset_mode_i,
  input  logic [BIT_WIDTH_REFRAC-1:0]              refractory_i,
  input  logic                                     update_valid_i,
  output logic                                     update_ready_o,
  input  logic [BIT_WIDTH_ADDR-1:0]                update_addr_i,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     update_value_i,
  input  logic                                     big_clear_i,
  input  logic                                     timestep_tick_i,
  output logic                                     spike_valid_o,
  output logic [BIT_WIDTH_ADDR-1:0]                spike_addr_o,
  output logic [NUM_NEURONS-1:0]                   spike_vector_o,
  output logic                                     scan_done_o,
  output logic                                     tick_overrun_o,
  input  logic [BIT_WIDTH_ADDR-1:0]                rd_addr_i,
  output logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_o
);

  localparam int N  = NUM_NEURONS;
  localparam int AW = BIT_WIDTH_ADDR;
  localparam int MW = BIT_WIDTH_MEMBRANE;
  localparam int BW = BIT_WIDTH_BIG_MEMBRANE;
  localparam int RW = BIT_WIDTH_REFRAC;

  logic signed [MW-1:0] mem_q [N];
  logic signed [BW-1:0] big_q [N];
  logic [RW-1:0]        ref_q [N];

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          sv_q;
  logic [AW-1:0] sa_q;
  logic [N-1:0]  vec_q, acc_q;
  logic          ovr_q;

  logic idle, scan, accept, last;

  assign idle   = (state_q == ST_IDLE);
  assign scan   = (state_q == ST_SCAN);
  assign accept = update_valid_i && idle;
  assign last   = (idx_q == AW'(N - 1));

  logic signed [MW-1:0] upd_sum;
  logic signed [BW-1:0] big_sum, big_ext;

  assign big_ext = BW'(update_value_i);

  neuron_sat_add #(.W(MW)) u_upd (
    .a_i   (mem_q[update_addr_i]),
    .b_i   (update_value_i),
    .sum_o (upd_sum)
  );

  neuron_sat_add #(.W(BW)) u_big (
    .a_i   (big_q[update_addr_i]),
    .b_i   (big_ext),
    .sum_o (big_sum)
  );

  logic signed [MW-1:0] sm, shr, leaked;
  logic signed [MW-1:0] sub, neg_thr, scan_m;
  logic                 fire;
  logic [N-1:0]         one_hot;

  assign sm      = mem_q[idx_q];
  assign shr     = sm >>> leak_shift_i;
  assign leaked  = (leak_shift_i == 4'd0) ? sm : sm - shr;
  assign fire    = (ref_q[idx_q] == '0) && (leaked >= threshold_i);
  assign neg_thr = -threshold_i;
  assign one_hot = N'(1) << idx_q;

  neuron_sat_add #(.W(MW)) u_thr (
    .a_i   (leaked),
    .b_i   (neg_thr),
    .sum_o (sub)
  );

  always_comb begin
    scan_m = leaked;
    if (fire) begin
      scan_m = (reset_mode_i == RESET_SUBTRACT) ? sub : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (timestep_tick_i) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        idx_d = idx_q + AW'(1);
        if (last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      sa_q    <= '0;
      vec_q   <= '0;
      acc_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      sv_q    <= scan && fire;
      sa_q    <= idx_q;
      if (scan && timestep_tick_i) ovr_q <= 1'b1;
      if (scan) begin
        if (last) begin
          vec_q <= acc_q | (fire ? one_hot : '0);
          acc_q <= '0;
        end else if (fire) begin
          acc_q <= acc_q | one_hot;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
        big_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      if (idle && big_clear_i) begin
        for (int i = 0; i < N; i++) big_q[i] <= '0;
      end else if (accept) begin
        big_q[update_addr_i] <= big_sum;
      end
      if (accept && ref_q[update_addr_i] == '0) begin
        mem_q[update_addr_i] <= upd_sum;
      end
      if (scan) begin
        if (ref_q[idx_q] != '0) begin
          ref_q[idx_q] <= ref_q[idx_q] - RW'(1);
        end else begin
          mem_q[idx_q] <= scan_m;
          if (fire) ref_q[idx_q] <= refractory_i;
        end
      end
    end
  end

  assign update_ready_o = idle;
  assign spike_valid_o  = sv_q;
  assign spike_addr_o   = sa_q;
  assign spike_vector_o = vec_q;
  assign scan_done_o    = done_q;
  assign tick_overrun_o = ovr_q;
  assign membrane_o     = mem_q[rd_addr_i];
  assign big_membrane_o = big_q[rd_addr_i];

endmodule

// File: doc/neuron_array_lif.md
# neuron_array_lif

Parametrised array of NUM_NEURONS leaky integrate-and-fire neurons with per-neuron membrane, big membrane and refractory state. It generalises the single-neuron membrane holder in four ways: addressed updates, saturating accumulation, a timestep-driven scan FSM (leak, threshold, spike, refractory), and a selectable reset mode. It sits between the synaptic accumulation stage, which sources updates, and the spike router or next layer, which sinks spike events.

## Interface
- NUM_NEURONS, 8: neuron count, power of two, ≥2
- BIT_WIDTH_ADDR, 3: log2(NUM_NEURONS)
- BIT_WIDTH_MEMBRANE, 16: signed membrane width
- BIT_WIDTH_BIG_MEMBRANE, 16: signed big-membrane width, ≥ BIT_WIDTH_MEMBRANE
- BIT_WIDTH_REFRAC, 4: refractory counter width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- threshold_i  in  BIT_WIDTH_MEMBRANE  signed threshold, must be >0
- leak_shift_i  in  4  leak = m>>>shift; 0 disables leak
- reset_mode_i  in  1  0 = reset to zero, 1 = subtract threshold
- refractory_i  in  BIT_WIDTH_REFRAC  timesteps of refractory after a spike
- update_valid_i  in  1  membrane delta valid
- update_ready_o  out  1  high in IDLE only
- update_addr_i  in  BIT_WIDTH_ADDR  target neuron
- update_value_i  in  BIT_WIDTH_MEMBRANE  signed delta
- big_clear_i  in  1  clear all big membranes; honoured in IDLE only
- timestep_tick_i  in  1  start scan
- spike_valid_o  out  1  one-cycle spike event
- spike_addr_o  out  BIT_WIDTH_ADDR  spiking neuron
- spike_vector_o  out  NUM_NEURONS  spikes of the last completed scan
- scan_done_o  out  1  one-cycle pulse at scan end
- tick_overrun_o  out  1  sticky: tick arrived outside IDLE
- rd_addr_i  in  BIT_WIDTH_ADDR  debug read address
- membrane_o  out  BIT_WIDTH_MEMBRANE  membrane[rd_addr_i], combinational read of registers
- big_membrane_o  out  BIT_WIDTH_BIG_MEMBRANE  big_membrane[rd_addr_i]

## Operation
- FSM states: IDLE, SCAN. IDLE→SCAN on timestep_tick_i. SCAN→IDLE after index NUM_NEURONS-1.
- Update accept condition: update_valid_i && update_ready_o.
  - Big membrane: big += sign-extended delta, saturating at the BIG width.
  - Membrane: if refractory count is 0, m += delta, saturating at BIT_WIDTH_MEMBRANE. Otherwise the membrane update is dropped.
- Update and tick in the same IDLE cycle: the update is applied and the scan starts next cycle.
- big_clear_i and an update in the same cycle: clear wins for all neurons; the update's big delta is lost. The membrane part of the update is still applied.
- Scan step for neuron j:
  - If ref>0: ref−1; membrane unchanged; no spike.
  - Else compute leaked L = m − (m>>>shift), or L = m when shift is 0.
  - If L ≥ threshold: spike; ref = refractory_i; m = 0 (mode 0) or sat(L − threshold) (mode 1).
  - Else m = L.
- Tick while in SCAN: ignored; sets tick_overrun_o.
- Reset values: all membranes, big membranes and ref counters 0; state IDLE. update_ready_o=1; all other outputs 0.
- Reset mid-scan: immediate return to IDLE. No further spikes and no scan_done_o.

## Timing
- Tick at cycle t: neuron j is processed at t+1+j, and its spike_valid_o/spike_addr_o (registered) appear at t+2+j.
- At t+1+N:
  - scan_done_o pulses.
  - spike_vector_o is updated, and is held until the next scan end.
  - update_ready_o is high again.
- Scan latency: NUM_NEURONS+1 cycles, tick to done.
- update_ready_o is low from t+1 through t+N.
- Upstream holds valid, address and value until ready.

## Structure
- Shared package neuron_pkg:
  - FSM state enum.
  - Reset-mode constants RESET_ZERO and RESET_SUBTRACT.
  - Saturation limit helpers.
- Sub-module neuron_sat_add: parametrised signed saturating adder. One instance on the update path, one on the big-membrane path, and one for threshold subtract.

## Test plan
- Reset with defaults, threshold 100, shift 0, mode 0, refractory 0:
  - Update neuron 3 by +60 twice, then tick → spike_valid_o at t+5 with addr 3.
  - spike_vector_o=8'h08 at t+9; membrane[3]=0; big_membrane[3]=120.
- Mode 1, threshold 100: membrane 130, tick → spike; membrane 30.
- Leak: shift 2, membrane 64, threshold 100, tick → no spike; membrane 48.
- Refractory 2:
  - After a spike, an update of +200 is dropped.
  - Next two ticks give no spike and ref goes 2→1→0.
  - The third tick scans normally.
- Saturation: membrane 32000 plus an update of +1000 → 32767. Updates of −1000 from −32000 → −32768.
- Tick at t+3 of a scan → tick_overrun_o=1, with only one scan_done_o. reset_n low at t+4 → no scan_done_o, all state 0.
